// File: rtl/sdram_access_ctrl.sv
// SDRAM access controller: after initialisation, schedules periodic AUTO REFRESH
// and single-word read/write accesses (ACTIVATE -> READ/WRITE with auto-precharge)
// for one client port. All DRAM and client outputs are registered.
module sdram_access_ctrl #(
  parameter int unsigned TRCD         = 2,
  parameter int unsigned TRP          = 2,
  parameter int unsigned TWR          = 2,
  parameter int unsigned TRFC         = 7,
  parameter int unsigned CAS_LAT      = 2,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iinit_done,
  input  logic        ireq,
  input  logic        iwr,
  input  logic [23:0] iaddr,
  input  logic [15:0] iwdata,
  output logic        oack,
  output logic [15:0] ordata,
  output logic        ordata_valid,
  output logic        obusy,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_LDQM,
  output logic [15:0] odq,
  output logic        odq_oe,
  input  logic [15:0] idq
);

  localparam int unsigned RD_WAIT_CYC = (CAS_LAT > TRP) ? CAS_LAT : TRP;
  localparam int unsigned WR_WAIT_CYC = TWR + TRP - 1;
  localparam int unsigned MAX_A       = (TRFC > TRCD) ? TRFC : TRCD;
  localparam int unsigned MAX_B       = (RD_WAIT_CYC > WR_WAIT_CYC) ? RD_WAIT_CYC : WR_WAIT_CYC;
  localparam int unsigned WAIT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W       = $clog2(WAIT_MAX + 1);
  localparam int unsigned REF_W       = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [3:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_REFRESH,
    ST_RFC_WAIT,
    ST_ACT,
    ST_RCD_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REF_W-1:0]   ref_cnt_q;
  logic               ref_pending_q;
  logic               ref_wrap;
  logic               req_wr_q;
  logic [23:0]        req_addr_q;
  logic [15:0]        req_wdata_q;
  logic [23:0]        op_addr;
  logic [CAS_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic [3:0]         cmd_q, cmd_d;
  logic [12:0]        addr_d;
  logic [1:0]         ba_d;
  logic [1:0]         dqm_q, dqm_d;
  logic [15:0]        odq_d;
  logic               oe_d, ack_d, busy_d;

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
  assign {DRAM_UDQM, DRAM_LDQM} = dqm_q;

  assign ref_wrap  = iinit_done && (ref_cnt_q == REF_W'(REF_INTERVAL - 1));
  // ACTIVATE is decided while still in IDLE, before the operands are latched
  assign op_addr   = (state_q == ST_IDLE) ? iaddr : req_addr_q;
  // One bit per cycle since READ; the top bit marks the data-capture cycle
  assign rd_pipe_d = CAS_LAT'({rd_pipe_q, (state_q == ST_RD)});

  // Next state, wait counter and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    ba_d    = '0;
    dqm_d   = 2'b00;
    odq_d   = odq;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    busy_d  = 1'b1;

    case (state_q)
      ST_WAIT_INIT: if (iinit_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending_q)  state_d = ST_REFRESH;
        else if (ireq)      state_d = ST_ACT;
      end
      ST_REFRESH: begin
        if (TRFC > 1) begin
          state_d = ST_RFC_WAIT;
          cnt_d   = CNT_W'(TRFC - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RFC_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACT: begin
        if (TRCD > 1) begin
          state_d = ST_RCD_WAIT;
          cnt_d   = CNT_W'(TRCD - 1);
        end else begin
          state_d = req_wr_q ? ST_WR : ST_RD;
        end
      end
      ST_RCD_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = req_wr_q ? ST_WR : ST_RD;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
        cnt_d   = CNT_W'(RD_WAIT_CYC);
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR: begin
        state_d = ST_WR_WAIT;
        cnt_d   = CNT_W'(WR_WAIT_CYC);
      end
      ST_WR_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_WAIT_INIT;
    endcase

    case (state_d)
      ST_WAIT_INIT: dqm_d = 2'b11;
      ST_IDLE:      busy_d = 1'b0;
      ST_REFRESH:   cmd_d = CMD_REF;
      ST_ACT: begin
        cmd_d  = CMD_ACT;
        ba_d   = op_addr[23:22];
        addr_d = op_addr[21:9];
        ack_d  = 1'b1;
      end
      ST_RD: begin
        cmd_d  = CMD_RD;
        ba_d   = op_addr[23:22];
        addr_d = {2'b00, 1'b1, 1'b0, op_addr[8:0]};
      end
      ST_WR: begin
        cmd_d  = CMD_WR;
        ba_d   = op_addr[23:22];
        addr_d = {2'b00, 1'b1, 1'b0, op_addr[8:0]};
        odq_d  = req_wdata_q;
        oe_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, wait counter, refresh timer and request operand latch
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q       <= ST_WAIT_INIT;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      req_wr_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      rd_pipe_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pipe_q <= rd_pipe_d;
      if (iinit_done) ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
      if (state_d == ST_REFRESH) ref_pending_q <= 1'b0;
      else if (ref_wrap)         ref_pending_q <= 1'b1;
      if ((state_q == ST_IDLE) && (state_d == ST_ACT)) begin
        req_wr_q    <= iwr;
        req_addr_q  <= iaddr;
        req_wdata_q <= iwdata;
      end
    end
  end

  // Registered DRAM bus and client outputs
  always_ff @(posedge iclk) begin
    if (ireset) begin
      cmd_q        <= CMD_NOP;
      DRAM_ADDR    <= '0;
      DRAM_BA      <= '0;
      dqm_q        <= 2'b11;
      odq          <= '0;
      odq_oe       <= 1'b0;
      oack         <= 1'b0;
      obusy        <= 1'b1;
      ordata       <= '0;
      ordata_valid <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      DRAM_ADDR    <= addr_d;
      DRAM_BA      <= ba_d;
      dqm_q        <= dqm_d;
      odq          <= odq_d;
      odq_oe       <= oe_d;
      oack         <= ack_d;
      obusy        <= busy_d;
      ordata_valid <= rd_pipe_q[CAS_LAT-1];
      if (rd_pipe_q[CAS_LAT-1]) ordata <= idq;
    end
  end

endmodule
